// File: rtl/uart.sv
// UART transceiver: shared 16x baud tick generator, 8N1 TX and RX FSMs,
// 2-flop rxd synchronizer.
// Optional even parity bit after data bit 7 when UART_PARITY_EN is defined.
module uart #(
  parameter int CLK_FREQ = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] baud_sel,
  input  logic       enable_baud,
  input  logic       tran_start,
  input  logic [7:0] trans_data,
  input  logic       rxd,
  output logic       txd,
  output logic       tx_busy,
  output logic [7:0] o_data,
  output logic       o_data_valid
);

  function automatic logic [15:0] div_of(input int baud);
    int d;
    d = CLK_FREQ / (16 * baud);
    if (d < 1) d = 1;
    return d[15:0];
  endfunction

  localparam logic [15:0] DIV0 = div_of(9600);
  localparam logic [15:0] DIV1 = div_of(19200);
  localparam logic [15:0] DIV2 = div_of(57600);
  localparam logic [15:0] DIV3 = div_of(115200);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_PARITY_EN
    S_PAR,
`endif
    S_STOP
  } state_t;

  logic [15:0] div, bcnt;
  logic        tick;

  // Divisor follows baud_sel directly; the counter compares against it on every
  // cycle, so a change lands no later than the next reload.
  always_comb begin
    case (baud_sel)
      2'b00:   div = DIV0;
      2'b01:   div = DIV1;
      2'b10:   div = DIV2;
      default: div = DIV3;
    endcase
  end

  assign tick = enable_baud && (bcnt >= div - 16'd1);

  // Baud counter: holds while enable_baud is low, reloads on each tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              bcnt <= '0;
    else if (enable_baud) bcnt <= tick ? 16'd0 : bcnt + 16'd1;
  end

  // ---------------- TX ----------------
  state_t     tx_state, tx_state_n;
  logic [3:0] tx_cnt, tx_cnt_n;
  logic [2:0] tx_bit, tx_bit_n;
  logic [7:0] tx_sh, tx_sh_n;
  logic       txd_n;

  assign tx_busy = (tx_state != S_IDLE);

  // TX next state; txd is registered from the next state so it moves with it.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_sh_n    = tx_sh;
    if (tx_state == S_IDLE) begin
      if (tran_start) begin
        tx_state_n = S_START;
        tx_sh_n    = trans_data;
        tx_cnt_n   = '0;
        tx_bit_n   = '0;
      end
    end else if (tick) begin
      tx_cnt_n = tx_cnt + 4'd1;
      if (tx_cnt == 4'd15) begin
        case (tx_state)
          S_START: tx_state_n = S_DATA;
          S_DATA: begin
            if (tx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
              tx_state_n = S_PAR;
`else
              tx_state_n = S_STOP;
`endif
            end else begin
              tx_bit_n = tx_bit + 3'd1;
            end
          end
`ifdef UART_PARITY_EN
          S_PAR:   tx_state_n = S_STOP;
`endif
          default: tx_state_n = S_IDLE;
        endcase
      end
    end
    case (tx_state_n)
      S_START: txd_n = 1'b0;
      S_DATA:  txd_n = tx_sh_n[tx_bit_n];
`ifdef UART_PARITY_EN
      S_PAR:   txd_n = ^tx_sh_n;
`endif
      default: txd_n = 1'b1;
    endcase
  end

  // TX state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      txd      <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_sh    <= tx_sh_n;
      txd      <= txd_n;
    end
  end

  // ---------------- RX ----------------
  logic       rx_s1, rx_s2;
  state_t     rx_state, rx_state_n;
  logic [3:0] rx_cnt, rx_cnt_n;
  logic [2:0] rx_bit, rx_bit_n;
  logic [7:0] rx_sh, rx_sh_n;
  logic [7:0] o_data_n;
  logic       o_data_valid_n;
`ifdef UART_PARITY_EN
  logic       rx_perr, rx_perr_n;
`endif

  // rxd synchronizer, reset to idle-high so release never looks like a start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rxd;
      rx_s2 <= rx_s1;
    end
  end

  // RX next state: recheck at mid-start, then sample every 16 ticks at bit centre.
  always_comb begin
    rx_state_n     = rx_state;
    rx_cnt_n       = rx_cnt;
    rx_bit_n       = rx_bit;
    rx_sh_n        = rx_sh;
    o_data_n       = o_data;
    o_data_valid_n = 1'b0;
`ifdef UART_PARITY_EN
    rx_perr_n      = rx_perr;
`endif
    if (rx_state == S_IDLE) begin
      if (!rx_s2) begin
        rx_state_n = S_START;
        rx_cnt_n   = '0;
        rx_bit_n   = '0;
      end
    end else if (tick) begin
      rx_cnt_n = rx_cnt + 4'd1;
      case (rx_state)
        S_START: begin
          if (rx_cnt == 4'd7) begin
            rx_cnt_n   = '0;
            rx_state_n = rx_s2 ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (rx_cnt == 4'd15) begin
            rx_sh_n[rx_bit] = rx_s2;
            if (rx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
              rx_state_n = S_PAR;
`else
              rx_state_n = S_STOP;
`endif
            end else begin
              rx_bit_n = rx_bit + 3'd1;
            end
          end
        end
`ifdef UART_PARITY_EN
        S_PAR: begin
          if (rx_cnt == 4'd15) begin
            rx_perr_n  = rx_s2 ^ (^rx_sh);
            rx_state_n = S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (rx_cnt == 4'd15) begin
            rx_state_n = S_IDLE;
`ifdef UART_PARITY_EN
            if (rx_s2 && !rx_perr) begin
`else
            if (rx_s2) begin
`endif
              o_data_n       = rx_sh;
              o_data_valid_n = 1'b1;
            end
          end
        end
        default: rx_state_n = S_IDLE;
      endcase
    end
  end

  // RX state register and output byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state     <= S_IDLE;
      rx_cnt       <= '0;
      rx_bit       <= '0;
      rx_sh        <= '0;
      o_data       <= '0;
      o_data_valid <= 1'b0;
`ifdef UART_PARITY_EN
      rx_perr      <= 1'b0;
`endif
    end else begin
      rx_state     <= rx_state_n;
      rx_cnt       <= rx_cnt_n;
      rx_bit       <= rx_bit_n;
      rx_sh        <= rx_sh_n;
      o_data       <= o_data_n;
      o_data_valid <= o_data_valid_n;
`ifdef UART_PARITY_EN
      rx_perr      <= rx_perr_n;
`endif
    end
  end

endmodule

// File: tb/tb_uart.sv
// Bench for uart (default 8N1 build): loopback vector table plus hand-written
// timing, busy-ignore, glitch, framing, freeze and reset sequences.
`timescale 1ns/1ps
module tb_uart;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] baud_sel;
  logic       enable_baud;
  logic       tran_start;
  logic [7:0] trans_data;
  logic       rxd;
  logic       txd;
  logic       tx_busy;
  logic [7:0] o_data;
  logic       o_data_valid;
  logic       loop;
  logic       rxd_drv;

  assign rxd = loop ? txd : rxd_drv;

  uart #(.CLK_FREQ(50000000)) dut (
    .clk(clk), .rst(rst), .baud_sel(baud_sel), .enable_baud(enable_baud),
    .tran_start(tran_start), .trans_data(trans_data), .rxd(rxd), .txd(txd),
    .tx_busy(tx_busy), .o_data(o_data), .o_data_valid(o_data_valid)
  );

  always #10 clk = ~clk;  // 50 MHz

  typedef struct {
    logic [7:0] data;
    logic [1:0] baud;
    logic [7:0] exp_data;
    int         exp_w;    // expected width of the first 1-run after start, 0 = skip
  } vec_t;

  vec_t       vecs[3];
  int         n_chk = 0;
  int         n_fail = 0;
  int         pulses = 0;
  logic [7:0] last_rx;

  always @(negedge clk) begin
    if (o_data_valid === 1'b1) begin
      pulses++;
      last_rx = o_data;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    trans_data = b;
    tran_start = 1'b1;
    @(negedge clk);
    tran_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (tx_busy === 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("tx_idle", {31'd0, tx_busy}, 32'd0);
  endtask

  task automatic wait_txd(input logic v, input int limit);
    int n;
    n = 0;
    while (txd !== v && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("txd_edge", {31'd0, txd}, {31'd0, v});
  endtask

  task automatic run_len(input int limit, output int n);
    logic v;
    v = txd;
    n = 0;
    while (txd === v && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic stop_v);
    rxd_drv = 1'b0;
    cycles(432);
    for (int b = 0; b < 8; b++) begin
      rxd_drv = d[b];
      cycles(432);
    end
    rxd_drv = stop_v;
    cycles(270);
    rxd_drv = 1'b1;
  endtask

  initial begin
    int   p0, w, bad;
    logic v;
    rst = 1'b1; baud_sel = 2'b00; enable_baud = 1'b1; tran_start = 1'b0;
    trans_data = 8'h00; loop = 1'b1; rxd_drv = 1'b1;
    vecs[0] = '{8'hA5, 2'b00, 8'hA5, 5200};
    vecs[1] = '{8'h3C, 2'b11, 8'h3C, 0};
    vecs[2] = '{8'hFF, 2'b11, 8'hFF, 0};

    cycles(3);
    chk("rst_txd",   {31'd0, txd},          32'd1);
    chk("rst_busy",  {31'd0, tx_busy},      32'd0);
    chk("rst_odata", {24'd0, o_data},       32'd0);
    chk("rst_valid", {31'd0, o_data_valid}, 32'd0);
    rst = 1'b0;
    cycles(3);

    // Loopback vectors
    for (int i = 0; i < 3; i++) begin
      baud_sel = vecs[i].baud;
      p0 = pulses;
      send(vecs[i].data);
      chk("accept_busy", {31'd0, tx_busy}, 32'd1);
      chk("accept_txd",  {31'd0, txd},     32'd0);
      if (vecs[i].exp_w != 0) begin
        wait_txd(1'b1, 6000);
        run_len(6000, w);
        chk("bit_width", w, vecs[i].exp_w);
      end
      wait_idle(60000);
      cycles(50);
      chk("vec_pulses", pulses - p0, 1);
      chk("vec_data", {24'd0, o_data}, {24'd0, vecs[i].exp_data});
    end

    // 0x55 at 115200: every data bit and the stop bit last 16*27 clocks
    p0 = pulses;
    send(8'h55);
    wait_txd(1'b1, 600);
    for (int k = 0; k < 8; k++) begin
      run_len(600, w);
      chk("bit_time", w, 432);
    end
    w = 0;
    while (tx_busy === 1'b1 && w < 600) begin
      @(negedge clk);
      w++;
    end
    chk("stop_time", w, 432);
    cycles(50);
    chk("t55_pulses", pulses - p0, 1);
    chk("t55_data", {24'd0, last_rx}, 32'h55);

    // Request while busy is ignored
    p0 = pulses;
    send(8'h12);
    cycles(1000);
    send(8'hFF);
    chk("busy_hold", {31'd0, tx_busy}, 32'd1);
    wait_idle(6000);
    cycles(50);
    chk("busy_pulses", pulses - p0, 1);
    chk("busy_data", {24'd0, o_data}, 32'h12);
    chk("busy_no_second", {31'd0, tx_busy}, 32'd0);

    // Short low glitch on rxd (3 tick periods) is a false start
    loop = 1'b0;
    p0 = pulses;
    rxd_drv = 1'b0;
    cycles(81);
    rxd_drv = 1'b1;
    cycles(600);
    chk("glitch_pulses", pulses - p0, 0);

    // Stop bit forced low: byte discarded, o_data kept
    p0 = pulses;
    drive_frame(8'h5A, 1'b0);
    cycles(800);
    chk("frame_err_pulses", pulses - p0, 0);
    chk("frame_err_data", {24'd0, o_data}, 32'h12);

    // Freeze mid-frame with enable_baud low
    loop = 1'b1;
    p0 = pulses;
    send(8'h96);
    cycles(1500);
    enable_baud = 1'b0;
    v = txd;
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (txd !== v || tx_busy !== 1'b1) bad++;
    end
    chk("freeze_hold", bad, 0);
    enable_baud = 1'b1;
    wait_idle(6000);
    cycles(50);
    chk("freeze_pulses", pulses - p0, 1);
    chk("freeze_data", {24'd0, o_data}, 32'h96);

    // Reset mid-frame aborts immediately (txd is 0 during d1 of 0x81)
    p0 = pulses;
    send(8'h81);
    cycles(1000);
    rst = 1'b1;
    #1;
    chk("rstmid_txd",  {31'd0, txd},     32'd1);
    chk("rstmid_busy", {31'd0, tx_busy}, 32'd0);
    cycles(3);
    chk("rstmid_odata", {24'd0, o_data},       32'd0);
    chk("rstmid_valid", {31'd0, o_data_valid}, 32'd0);
    rst = 1'b0;
    cycles(1500);
    chk("rstmid_pulses", pulses - p0, 0);
    chk("rstmid_idle", {31'd0, tx_busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
